// File: rtl/uart_tx_mmio_pkg.sv
// uart_tx_mmio_pkg: shared constants, register offsets and TX FSM states for the MMIO UART transmitter.
`timescale 1ns/1ps
package uart_tx_mmio_pkg;
  localparam logic RstEnable = 1'b1;
  localparam logic ChipEnable = 1'b1;
  localparam logic WriteEnable = 1'b1;
  localparam logic [31:0] ZeroWord = 32'h0;
  localparam logic [1:0] UartTxDataAddr = 2'd0;
  localparam logic [1:0] UartStatusAddr = 2'd1;
  localparam logic [1:0] UartBaudAddr = 2'd2;
  typedef enum logic [1:0] {UartIdle, UartStart, UartData, UartStop} uart_state_e;
endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: synchronous byte FIFO; a push while full is accepted only if a pop happens on the same edge.
`timescale 1ns/1ps
module uart_tx_fifo import uart_tx_mmio_pkg::*; #(
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic [7:0]             din_i,
  output logic [7:0]             dout_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] level_o
);
  localparam int AW = $clog2(DEPTH);
  logic [7:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0] level_q;
  logic do_push, do_pop;
  assign do_pop = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign dout_o = mem_q[rd_q];
  assign full_o = level_q == (AW+1)'(DEPTH);
  assign empty_o = level_q == '0;
  assign level_o = level_q;
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din_i;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst == RstEnable) begin
      wr_q <= '0;
      rd_q <= '0;
      level_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop) rd_q <= rd_q + AW'(1);
      level_q <= level_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/uart_tx_mmio.sv
// uart_tx_mmio: memory-mapped 8N1 UART transmitter with TX FIFO, programmable divider and idle interrupt.
`timescale 1ns/1ps
module uart_tx_mmio import uart_tx_mmio_pkg::*; #(
  parameter int          FIFO_DEPTH     = 8,
  parameter logic [15:0] BAUD_DIV_RESET = 16'd433
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [3:0]  sel,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        txd,
  output logic        int_o
);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  uart_state_e state_q;
  logic [15:0] baud_q, baud_d, div_q, timer_q;
  logic [7:0] shift_q, fifo_dout;
  logic [2:0] bit_q;
  logic txd_q, int_q, ovf_q, ovf_d;
  logic wr, rd, push, pop, full, empty, tick;
  logic [LW-1:0] level;
  logic [31:0] level32;
  logic [3:0] level_sat;
  logic unused_bits;
  assign unused_bits = ^{addr[31:4], addr[1:0], sel[3:2], data_i[31:16]};
  assign wr = ce == ChipEnable && we == WriteEnable;
  assign rd = ce == ChipEnable && we != WriteEnable;
  assign push = wr && addr[3:2] == UartTxDataAddr && sel[0];
  assign tick = timer_q == 16'd0;
  assign pop = !empty && (state_q == UartIdle || (state_q == UartStop && tick));
  uart_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .rst(rst), .push_i(push), .pop_i(pop), .din_i(data_i[7:0]),
    .dout_o(fifo_dout), .full_o(full), .empty_o(empty), .level_o(level)
  );
  assign level32 = 32'(level);
  assign level_sat = level32 > 32'd15 ? 4'hf : level32[3:0];
  always_comb begin
    baud_d = (wr && addr[3:2] == UartBaudAddr && &sel[1:0]) ?
             (data_i[15:0] == 16'd0 ? 16'd1 : data_i[15:0]) : baud_q;
    ovf_d = (push && full && !pop) ? 1'b1 :
            (wr && addr[3:2] == UartStatusAddr && sel[0] && data_i[3]) ? 1'b0 : ovf_q;
    data_o = !rd ? ZeroWord :
             addr[3:2] == UartStatusAddr ? {24'd0, level_sat, ovf_q, empty, full, state_q != UartIdle} :
             addr[3:2] == UartBaudAddr ? {16'd0, baud_q} : ZeroWord;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst == RstEnable) begin
      baud_q <= BAUD_DIV_RESET;
      ovf_q <= 1'b0;
    end else begin
      baud_q <= baud_d;
      ovf_q <= ovf_d;
    end
  end
  // div_q freezes the divider per frame so BAUDDIV writes only affect the next frame
  always_ff @(posedge clk or posedge rst) begin
    if (rst == RstEnable) begin
      state_q <= UartIdle;
      div_q <= BAUD_DIV_RESET;
      timer_q <= '0;
      shift_q <= '0;
      bit_q <= '0;
      txd_q <= 1'b1;
      int_q <= 1'b1;
    end else begin
      int_q <= empty && state_q == UartIdle;
      if (pop) begin
        state_q <= UartStart;
        shift_q <= fifo_dout;
        div_q <= baud_q;
        timer_q <= baud_q;
        bit_q <= '0;
        txd_q <= 1'b0;
      end else if (state_q != UartIdle) begin
        if (!tick) timer_q <= timer_q - 16'd1;
        else begin
          timer_q <= div_q;
          case (state_q)
            UartStart: begin
              state_q <= UartData;
              txd_q <= shift_q[0];
              shift_q <= {1'b0, shift_q[7:1]};
            end
            UartData: begin
              if (bit_q == 3'd7) begin
                state_q <= UartStop;
                txd_q <= 1'b1;
              end else begin
                bit_q <= bit_q + 3'd1;
                txd_q <= shift_q[0];
                shift_q <= {1'b0, shift_q[7:1]};
              end
            end
            default: begin
              state_q <= UartIdle;
              txd_q <= 1'b1;
            end
          endcase
        end
      end
    end
  end
  assign txd = txd_q;
  assign int_o = int_q;
endmodule

// File: tb/tb_uart_tx_mmio.sv
// tb_uart_tx_mmio: register-access vector table plus directed serial-frame sequences with a line receiver model.
`timescale 1ns/1ps
module tb_uart_tx_mmio;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ce = 1'b0, we = 1'b0;
  logic [31:0] addr = '0, data_i = '0;
  logic [3:0] sel = '0;
  logic [31:0] data_o;
  logic txd, int_o;
  int nvec = 0, nerr = 0, cyc = 0;
  typedef struct {logic [7:0] b; logic stop; int cyc;} rx_t;
  rx_t rx[$];
  int per_q[$];
  int cur_p = 4;
  typedef struct {logic ce; logic we; logic [1:0] a; logic [3:0] sel; logic [31:0] d; logic [31:0] exp;} vec_t;
  vec_t tv[18];
  uart_tx_mmio dut (
    .clk(clk), .rst(rst), .ce(ce), .we(we), .addr(addr), .sel(sel),
    .data_i(data_i), .data_o(data_o), .txd(txd), .int_o(int_o)
  );
  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
    $fatal(1, "watchdog");
  end
  // line receiver: samples mid-bit with the period queued by the test, drops frames cut by reset
  initial begin
    logic [7:0] b;
    logic stop, ab;
    int st;
    forever begin
      @(negedge clk);
      if (!rst && txd === 1'b0) begin
        if (per_q.size() > 0) cur_p = per_q.pop_front();
        st = cyc;
        ab = 1'b0;
        b = '0;
        stop = 1'b0;
        for (int k = 1; k < 10 * cur_p; k++) begin
          @(negedge clk);
          if (rst) ab = 1'b1;
          if (k % cur_p == cur_p / 2) begin
            if (k / cur_p >= 1 && k / cur_p <= 8) b[k / cur_p - 1] = txd;
            if (k / cur_p == 9) stop = txd;
          end
        end
        if (!ab) rx.push_back('{b, stop, st});
      end
    end
  end
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask
  task automatic wr(input logic [1:0] a, input logic [31:0] d, input logic [3:0] s = 4'hf);
    ce = 1'b1; we = 1'b1; addr = {28'd0, a, 2'b00}; sel = s; data_i = d;
    @(posedge clk); #1;
    ce = 1'b0; we = 1'b0;
  endtask
  task automatic rd(input string n, input logic [1:0] a, input logic [31:0] e);
    ce = 1'b1; we = 1'b0; addr = {28'd0, a, 2'b00}; sel = 4'hf;
    @(negedge clk);
    chk(n, data_o, e);
    @(posedge clk); #1;
    ce = 1'b0;
  endtask
  task automatic wait_rx(input int n, input int lim);
    for (int i = 0; i < lim && rx.size() < n; i++) @(negedge clk);
    chk("rx_count", rx.size(), n);
  endtask
  task automatic wait_int(input int lim);
    for (int i = 0; i < lim && int_o !== 1'b1; i++) @(negedge clk);
    chk("int_idle", {31'd0, int_o}, 1);
  endtask
  initial begin
    logic [9:0] frame;
    tv[0]  = '{1'b1, 1'b0, 2'd1, 4'hf, 32'h0, 32'h4};
    tv[1]  = '{1'b1, 1'b0, 2'd2, 4'hf, 32'h0, 32'd433};
    tv[2]  = '{1'b1, 1'b0, 2'd0, 4'hf, 32'h0, 32'h0};
    tv[3]  = '{1'b1, 1'b0, 2'd3, 4'hf, 32'h0, 32'h0};
    tv[4]  = '{1'b0, 1'b0, 2'd2, 4'hf, 32'h0, 32'h0};
    tv[5]  = '{1'b1, 1'b1, 2'd3, 4'hf, 32'hff, 32'h0};
    tv[6]  = '{1'b1, 1'b1, 2'd2, 4'hf, 32'h0, 32'h0};
    tv[7]  = '{1'b1, 1'b0, 2'd2, 4'hf, 32'h0, 32'd1};
    tv[8]  = '{1'b1, 1'b1, 2'd2, 4'h1, 32'h1234, 32'h0};
    tv[9]  = '{1'b1, 1'b0, 2'd2, 4'hf, 32'h0, 32'd1};
    tv[10] = '{1'b1, 1'b1, 2'd2, 4'h3, 32'hABCD0007, 32'h0};
    tv[11] = '{1'b1, 1'b0, 2'd2, 4'hf, 32'h0, 32'd7};
    tv[12] = '{1'b1, 1'b1, 2'd1, 4'hf, 32'h8, 32'h0};
    tv[13] = '{1'b1, 1'b0, 2'd1, 4'hf, 32'h0, 32'h4};
    tv[14] = '{1'b1, 1'b1, 2'd0, 4'h2, 32'h77, 32'h0};
    tv[15] = '{1'b1, 1'b0, 2'd1, 4'hf, 32'h0, 32'h4};
    tv[16] = '{1'b1, 1'b1, 2'd2, 4'h3, 32'h3, 32'h0};
    tv[17] = '{1'b1, 1'b0, 2'd2, 4'hf, 32'h0, 32'd3};
    #195 rst = 1'b0;
    chk("reset_txd", {31'd0, txd}, 1);
    chk("reset_int", {31'd0, int_o}, 1);
    @(posedge clk); #1;
    for (int i = 0; i < 18; i++) begin
      ce = tv[i].ce; we = tv[i].we; addr = {28'd0, tv[i].a, 2'b00}; sel = tv[i].sel; data_i = tv[i].d;
      @(negedge clk);
      chk($sformatf("vec%0d", i), data_o, tv[i].exp);
      @(posedge clk); #1;
    end
    ce = 1'b0; we = 1'b0;
    // single byte 0x55 at 4 cycles/bit
    rx.delete();
    frame = {1'b1, 8'h55, 1'b0};
    wr(2'd0, 32'h55);
    @(negedge clk);
    chk("txd_before_pop", {31'd0, txd}, 1);
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      chk($sformatf("single_bit%0d", k), {31'd0, txd}, {31'd0, frame[k / 4]});
      if (k == 0) chk("int_fall", {31'd0, int_o}, 0);
    end
    @(negedge clk);
    chk("single_idle_txd", {31'd0, txd}, 1);
    chk("int_still_low", {31'd0, int_o}, 0);
    @(negedge clk);
    chk("int_rise", {31'd0, int_o}, 1);
    wait_rx(1, 20);
    chk("single_rx", {24'd0, rx[0].b}, 32'h55);
    // overflow: 10 back-to-back pushes, last one dropped
    repeat (5) @(posedge clk); #1;
    rx.delete();
    for (int i = 1; i <= 10; i++) wr(2'd0, i);
    rd("ovf_status", 2'd1, 32'h8B);
    wait_rx(9, 500);
    for (int i = 0; i < 9 && i < rx.size(); i++) begin
      chk($sformatf("ovf_byte%0d", i), {24'd0, rx[i].b}, i + 1);
      chk($sformatf("ovf_stop%0d", i), {31'd0, rx[i].stop}, 1);
    end
    wait_int(20);
    repeat (60) @(negedge clk);
    chk("ovf_no_extra", rx.size(), 9);
    @(posedge clk); #1;
    rd("ovf_sticky", 2'd1, 32'h0C);
    wr(2'd1, 32'h08);
    rd("ovf_cleared", 2'd1, 32'h04);
    // back-to-back frames with no idle gap
    rx.delete();
    wr(2'd0, 32'hA5);
    wr(2'd0, 32'h3C);
    wait_rx(2, 200);
    if (rx.size() >= 2) begin
      chk("b2b_first", {24'd0, rx[0].b}, 32'hA5);
      chk("b2b_second", {24'd0, rx[1].b}, 32'h3C);
      chk("b2b_gap", 32'(rx[1].cyc - rx[0].cyc), 40);
    end
    wait_int(20);
    // divider change mid-frame applies to the next frame only
    @(posedge clk); #1;
    rx.delete();
    per_q.push_back(4);
    per_q.push_back(8);
    wr(2'd0, 32'hFF);
    wr(2'd0, 32'h5A);
    repeat (6) @(posedge clk); #1;
    wr(2'd2, 32'd7);
    wait_rx(2, 300);
    if (rx.size() >= 2) begin
      chk("baud_first", {24'd0, rx[0].b}, 32'hFF);
      chk("baud_gap", 32'(rx[1].cyc - rx[0].cyc), 40);
      chk("baud_second", {24'd0, rx[1].b}, 32'h5A);
      chk("baud_second_stop", {31'd0, rx[1].stop}, 1);
    end
    wait_int(20);
    @(posedge clk); #1;
    rd("baud_readback", 2'd2, 32'd7);
    // reset during data bit 4
    per_q.push_back(4);
    wr(2'd2, 32'd3);
    rx.delete();
    wr(2'd0, 32'h00);
    wr(2'd0, 32'h00);
    repeat (22) @(negedge clk);
    chk("rst_pre_txd", {31'd0, txd}, 0);
    rst = 1'b1;
    #1;
    chk("rst_async_txd", {31'd0, txd}, 1);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    rd("rst_status", 2'd1, 32'h04);
    rd("rst_baud", 2'd2, 32'd433);
    chk("rst_int", {31'd0, int_o}, 1);
    repeat (120) @(negedge clk);
    chk("rst_no_frame", rx.size(), 0);
    chk("rst_idle_txd", {31'd0, txd}, 1);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
